// File: rtl/fsmc_bus_master.sv
// FSMC-style asynchronous SRAM bus master.
// Each access runs ADDR (address setup), DATA (strobe low), then TURN
// (bus turnaround). Every output is a flop loaded from the next-state
// decode, so bus pins change cleanly on clock edges and no input reaches
// an output combinationally.
module fsmc_bus_master #(
   parameter int ADRW    = 1,
   parameter int DATW    = 3,
   parameter int ADDSET  = 2,
   parameter int DATAST  = 6,
   parameter int BUSTURN = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req,
   input  logic            req_write,
   input  logic [ADRW-1:0] req_adr,
   input  logic [DATW-1:0] req_wdata,
   output logic            busy,
   output logic            done,
   output logic [DATW-1:0] rd_data,
   output logic            NE,
   output logic            NOE,
   output logic            NWE,
   output logic [ADRW-1:0] An,
   output logic [DATW-1:0] Dn_out,
   output logic            Dn_oe,
   input  logic [DATW-1:0] Dn_in
);

   // Six bits cover the largest phase (DATAST up to 63). The counter is
   // loaded with length-1 on phase entry and counts down to zero, so it
   // never wraps inside a phase.
   localparam int CNTW = 6;
   localparam logic [CNTW-1:0] ADDSET_LAST  = CNTW'(ADDSET - 1);
   localparam logic [CNTW-1:0] DATAST_LAST  = CNTW'(DATAST - 1);
   localparam logic [CNTW-1:0] BUSTURN_LAST = CNTW'(BUSTURN - 1);

   typedef enum logic [1:0] {IDLE, ADDR, DATA, TURN} state_t;

   state_t            state_reg, state_next;
   logic [CNTW-1:0]   cnt_reg, cnt_next;
   logic              wr_reg;
   logic              wr_next;
   logic              accept;
   logic              data_end;

   // Direction of the access that occupies the next cycle: a freshly
   // accepted request overrides the stored one on the acceptance edge.
   assign wr_next = accept ? req_write : wr_reg;

   // State and phase counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   // Next-state decode: requests are only looked at in IDLE, so anything
   // arriving while busy is simply dropped.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      accept     = 1'b0;
      data_end   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (req) begin
               accept     = 1'b1;
               state_next = ADDR;
               cnt_next   = ADDSET_LAST;
            end
         end
         ADDR: begin
            if (cnt_reg == '0) begin
               state_next = DATA;
               cnt_next   = DATAST_LAST;
            end else begin
               cnt_next = cnt_reg - CNTW'(1);
            end
         end
         DATA: begin
            if (cnt_reg == '0) begin
               data_end   = 1'b1;
               state_next = TURN;
               cnt_next   = BUSTURN_LAST;
            end else begin
               cnt_next = cnt_reg - CNTW'(1);
            end
         end
         TURN: begin
            if (cnt_reg == '0) begin
               state_next = IDLE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg - CNTW'(1);
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   // Registered bus pins and handshake outputs, decoded from the state the
   // FSM is entering so they line up exactly with the phase boundaries.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_reg  <= 1'b0;
         An      <= '0;
         Dn_out  <= '0;
         Dn_oe   <= 1'b0;
         NE      <= 1'b1;
         NOE     <= 1'b1;
         NWE     <= 1'b1;
         busy    <= 1'b0;
         done    <= 1'b0;
         rd_data <= '0;
      end else begin
         if (accept) begin
            wr_reg <= req_write;
            An     <= req_adr;
            Dn_out <= req_wdata;
         end
         NE    <= !(state_next == ADDR || state_next == DATA);
         NOE   <= !(state_next == DATA && !wr_next);
         NWE   <= !(state_next == DATA && wr_next);
         Dn_oe <= (state_next == DATA) && wr_next;
         busy  <= (state_next != IDLE);
         done  <= data_end;
         // Pad data is taken on the edge that closes the read strobe.
         if (data_end && !wr_reg) begin
            rd_data <= Dn_in;
         end
      end
   end

endmodule

// File: tb/tb_fsmc_bus_master.sv
// Self-checking bench for fsmc_bus_master: a cycle-offset reference model
// checked every cycle, directed scenarios with literal expectations, and a
// small SRAM slave loop-back on a second, fast-timed instance.
module tb_fsmc_bus_master;

   localparam int AW = 1;
   localparam int DW = 3;
   localparam int AS = 2;
   localparam int DS = 6;
   localparam int BT = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req = 1'b0;
   logic          req_write = 1'b0;
   logic [AW-1:0] req_adr = '0;
   logic [DW-1:0] req_wdata = '0;
   logic [DW-1:0] dn_in = '0;
   logic          busy, done, NE, NOE, NWE, Dn_oe;
   logic [DW-1:0] rd_data, Dn_out;
   logic [AW-1:0] An;

   // loop-back instance signals
   logic          lb_req = 1'b0;
   logic          lb_write = 1'b0;
   logic [AW-1:0] lb_adr = '0;
   logic [DW-1:0] lb_wdata = '0;
   logic          lb_busy, lb_done, lb_ne, lb_noe, lb_nwe, lb_oe;
   logic [DW-1:0] lb_rd, lb_dout, lb_din;
   logic [AW-1:0] lb_an;
   logic [DW-1:0] sram [0:1];

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   fsmc_bus_master #(.ADRW(AW), .DATW(DW), .ADDSET(AS), .DATAST(DS), .BUSTURN(BT)) dut (
      .clk(clk), .rst(rst), .req(req), .req_write(req_write), .req_adr(req_adr),
      .req_wdata(req_wdata), .busy(busy), .done(done), .rd_data(rd_data),
      .NE(NE), .NOE(NOE), .NWE(NWE), .An(An), .Dn_out(Dn_out), .Dn_oe(Dn_oe),
      .Dn_in(dn_in));

   fsmc_bus_master #(.ADRW(AW), .DATW(DW), .ADDSET(1), .DATAST(2), .BUSTURN(3)) u_lb (
      .clk(clk), .rst(rst), .req(lb_req), .req_write(lb_write), .req_adr(lb_adr),
      .req_wdata(lb_wdata), .busy(lb_busy), .done(lb_done), .rd_data(lb_rd),
      .NE(lb_ne), .NOE(lb_noe), .NWE(lb_nwe), .An(lb_an), .Dn_out(lb_dout), .Dn_oe(lb_oe),
      .Dn_in(lb_din));

   // Simple asynchronous SRAM slave for the loop-back instance.
   initial begin
      sram[0] = '0;
      sram[1] = '0;
   end
   always @(posedge clk) if (!lb_ne && !lb_nwe) sram[lb_an] <= lb_dout;
   assign lb_din = (!lb_ne && !lb_noe) ? sram[lb_an] : '0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model: position within the access ----------
   bit            m_act = 1'b0;
   int            m_t = 0;
   bit            m_w = 1'b0;
   logic [AW-1:0] m_an = '0;
   logic [DW-1:0] m_dout = '0;
   logic [DW-1:0] m_rd = '0;

   always @(posedge clk) begin
      if (rst) begin
         m_act = 1'b0; m_t = 0; m_an = '0; m_dout = '0; m_rd = '0;
      end else if (m_act) begin
         if (m_t == AS + DS - 1 && !m_w) m_rd = dn_in;
         m_t++;
         if (m_t == AS + DS + BT) m_act = 1'b0;
      end else if (req) begin
         m_act = 1'b1; m_t = 0; m_w = req_write; m_an = req_adr; m_dout = req_wdata;
      end
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         automatic bit strobe = m_act && (m_t < AS + DS);
         automatic bit in_data = m_act && (m_t >= AS) && (m_t < AS + DS);
         chk("cyc_NE",      32'(NE),      32'(!strobe));
         chk("cyc_NOE",     32'(NOE),     32'(!(in_data && !m_w)));
         chk("cyc_NWE",     32'(NWE),     32'(!(in_data && m_w)));
         chk("cyc_Dn_oe",   32'(Dn_oe),   32'(in_data && m_w));
         chk("cyc_busy",    32'(busy),    32'(m_act));
         chk("cyc_done",    32'(done),    32'(m_act && m_t == AS + DS));
         chk("cyc_An",      32'(An),      32'(m_an));
         chk("cyc_Dn_out",  32'(Dn_out),  32'(m_dout));
         chk("cyc_rd_data", 32'(rd_data), 32'(m_rd));
      end
   end

   // ---------------- waveform statistics for literal expectations ---------
   int ne_low, nwe_low, noe_low, wr_drive, oe_bad, busy_cnt, done_cnt;
   int hi_run = 0;
   int last_gap = 0;
   bit ne_prev = 1'b1;

   always @(negedge clk) begin
      if (NE === 1'b0) ne_low++;
      if (NWE === 1'b0) nwe_low++;
      if (NOE === 1'b0) noe_low++;
      if (NWE === 1'b0 && Dn_oe === 1'b1 && Dn_out === 3'b101) wr_drive++;
      if (NOE === 1'b0 && Dn_oe !== 1'b0) oe_bad++;
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) done_cnt++;
      if (NE === 1'b0) begin
         if (ne_prev) last_gap = hi_run;
         hi_run = 0;
         ne_prev = 1'b0;
      end else begin
         hi_run++;
         ne_prev = 1'b1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic clear_stats();
      ne_low = 0; nwe_low = 0; noe_low = 0; wr_drive = 0;
      oe_bad = 0; busy_cnt = 0; done_cnt = 0;
   endtask

   task automatic start_access(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req = 1'b1; req_write = w; req_adr = a; req_wdata = d;
      tick();
      req = 1'b0;
   endtask

   task automatic wait_idle(input string nm);
      for (int i = 0; i < 100 && busy; i++) tick();
      chk(nm, 32'(busy), 32'(0));
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      clear_stats();
      // reset state
      repeat (3) tick();
      chk("rst_NE", 32'(NE), 32'(1));
      chk("rst_NOE", 32'(NOE), 32'(1));
      chk("rst_NWE", 32'(NWE), 32'(1));
      chk("rst_Dn_oe", 32'(Dn_oe), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_done", 32'(done), 32'(0));
      chk("rst_An", 32'(An), 32'(0));
      chk("rst_Dn_out", 32'(Dn_out), 32'(0));
      chk("rst_rd_data", 32'(rd_data), 32'(0));
      chk_en = 1'b1;
      rst = 1'b0;
      repeat (2) tick();

      // single write, adr 1 data 101
      clear_stats();
      start_access(1'b1, 1'b1, 3'b101);
      wait_idle("wr_idle_timeout");
      repeat (2) tick();
      chk("wr_ne_low", 32'(ne_low), 32'(8));
      chk("wr_nwe_low", 32'(nwe_low), 32'(6));
      chk("wr_drive", 32'(wr_drive), 32'(6));
      chk("wr_busy", 32'(busy_cnt), 32'(12));
      chk("wr_done", 32'(done_cnt), 32'(1));
      $display("txn write adr=1 data=101 done");

      // single read, adr 0, pad returns 110
      clear_stats();
      dn_in = 3'b110;
      start_access(1'b0, 1'b0, 3'b010);
      for (int i = 0; i < 100 && !done; i++) tick();
      chk("rd_done_seen", 32'(done), 32'(1));
      chk("rd_data_at_done", 32'(rd_data), 32'(3'b110));
      wait_idle("rd_idle_timeout");
      tick();
      chk("rd_noe_low", 32'(noe_low), 32'(6));
      chk("rd_oe_bad", 32'(oe_bad), 32'(0));
      chk("rd_done_cnt", 32'(done_cnt), 32'(1));
      $display("txn read adr=0 rd_data=%b", rd_data);

      // back-to-back writes with req held high
      clear_stats();
      req = 1'b1; req_write = 1'b1; req_adr = 1'b0; req_wdata = 3'b011;
      tick();
      for (int i = 0; i < 100 && done_cnt < 1; i++) tick();
      for (int i = 0; i < 100 && busy; i++) tick();
      tick();
      req = 1'b0;
      wait_idle("b2b_idle_timeout");
      tick();
      chk("b2b_done_cnt", 32'(done_cnt), 32'(2));
      chk("b2b_gap", 32'(last_gap), 32'(BT + 1));
      chk("b2b_ne_low", 32'(ne_low), 32'(16));
      $display("txn back-to-back writes gap=%0d", last_gap);

      // req toggled while a read is in flight
      clear_stats();
      dn_in = 3'b001;
      start_access(1'b0, 1'b1, 3'b000);
      for (int i = 0; i < 10; i++) begin
         req = ~req; req_write = ~req_write; req_adr = ~req_adr;
         tick();
      end
      req = 1'b0;
      wait_idle("tgl_idle_timeout");
      repeat (3) tick();
      chk("tgl_done_cnt", 32'(done_cnt), 32'(1));
      chk("tgl_ne_low", 32'(ne_low), 32'(8));
      chk("tgl_rd_data", 32'(rd_data), 32'(3'b001));
      $display("txn read with req toggling rd_data=%b", rd_data);

      // reset on the third DATA cycle of a read
      clear_stats();
      dn_in = 3'b111;
      start_access(1'b0, 1'b1, 3'b000);
      repeat (4) tick();
      rst = 1'b1;
      tick();
      chk("abort_NE", 32'(NE), 32'(1));
      chk("abort_NOE", 32'(NOE), 32'(1));
      chk("abort_done", 32'(done), 32'(0));
      chk("abort_rd_data", 32'(rd_data), 32'(0));
      chk("abort_busy", 32'(busy), 32'(0));
      // request coinciding with reset is ignored
      req = 1'b1;
      tick();
      rst = 1'b0; req = 1'b0;
      repeat (2) tick();
      chk("rstreq_busy", 32'(busy), 32'(0));
      chk("abort_done_cnt", 32'(done_cnt), 32'(0));
      $display("txn read aborted by reset");

      // loop-back against SRAM slave, fast timing
      lb_req = 1'b1; lb_write = 1'b1; lb_adr = 1'b1; lb_wdata = 3'b011;
      tick();
      lb_req = 1'b0;
      for (int i = 0; i < 100 && lb_busy; i++) tick();
      chk("lb_wr_idle", 32'(lb_busy), 32'(0));
      lb_req = 1'b1; lb_write = 1'b0; lb_adr = 1'b1; lb_wdata = 3'b000;
      tick();
      lb_req = 1'b0;
      for (int i = 0; i < 100 && !lb_done; i++) tick();
      chk("lb_done_seen", 32'(lb_done), 32'(1));
      chk("lb_rd_data", 32'(lb_rd), 32'(3'b011));
      $display("txn loopback write/read adr=1 rd_data=%b", lb_rd);
      repeat (6) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fsmc_bus_master.md
FSMC_BUS_MASTER -- requirements
Module: fsmc_bus_master

Interface
REQ-001 Parameter ADRW, default 1, address width in bits.
REQ-002 Parameter DATW, default 3, data width in bits.
REQ-003 Parameter ADDSET, default 2, address-setup phase length in clk cycles (legal 1..15).
REQ-004 Parameter DATAST, default 6, strobe-low phase length in clk cycles (legal 2..63).
REQ-005 Parameter BUSTURN, default 4, idle gap after each access in clk cycles (legal 3..15).
REQ-006 clk  input  1  single clock; all logic on its rising edge.
REQ-007 rst  input  1  reset, synchronous and active-high.
REQ-008 req  input  1  request strobe; sampled only when busy=0.
REQ-009 req_write  input  1  1 = write access, 0 = read access.
REQ-010 req_adr  input  ADRW  access address.
REQ-011 req_wdata  input  DATW  write data.
REQ-012 busy  output  1  high from the cycle after acceptance until the end of the turnaround phase.
REQ-013 done  output  1  single-cycle pulse marking access completion.
REQ-014 rd_data  output  DATW  data captured by the last read.
REQ-015 NE  output  1  chip enable, active low.
REQ-016 NOE  output  1  output enable (read strobe), active low.
REQ-017 NWE  output  1  write enable, active low.
REQ-018 An  output  ADRW  bus address.
REQ-019 Dn_out  output  DATW  bus write data.
REQ-020 Dn_oe  output  1  data pad output enable (1 = drive Dn_out).
REQ-021 Dn_in  input  DATW  bus data from the pad; sampled without synchroniser.

Function
REQ-022 States SHALL be IDLE, ADDR, DATA, TURN; encoding is free.
REQ-023 All bus outputs, busy, done and rd_data SHALL be registered; no combinational input-to-output path.
REQ-024 IDLE: NE=NOE=NWE=1, Dn_oe=0, busy=0; req=1 SHALL capture req_write, req_adr, req_wdata and move to ADDR on that edge.
REQ-025 ADDR: NE=0, An=captured address, NOE=NWE=1; lasts exactly ADDSET cycles.
REQ-026 DATA (write): NE=0, NWE=0, Dn_oe=1, Dn_out=captured data; lasts exactly DATAST cycles.
REQ-027 DATA (read): NE=0, NOE=0, Dn_oe=0; rd_data SHALL load Dn_in on the edge ending the last DATA cycle; lasts exactly DATAST cycles.
REQ-028 An SHALL stay constant from the first ADDR cycle through the last DATA cycle.
REQ-029 TURN: NE=NOE=NWE=1, Dn_oe=0; lasts exactly BUSTURN cycles, then IDLE.
REQ-030 done SHALL be 1 during the first TURN cycle only; rd_data is valid when done=1 and holds until the next read completes.
REQ-031 busy SHALL be 1 in ADDR, DATA and TURN; req with busy=1 SHALL be ignored, not queued.
REQ-032 A req held high through TURN SHALL be accepted on the first IDLE cycle, so back-to-back accesses have exactly BUSTURN+1 cycles with NE=1 between them.
REQ-033 NOE and NWE SHALL never be low at the same time; Dn_oe SHALL never be 1 while NOE=0.
REQ-034 Phase counters SHALL be wide enough for the parameter maxima and SHALL not wrap inside a phase.

Reset
REQ-035 While rst=1 on an edge: state=IDLE, NE=NOE=NWE=1, Dn_oe=0, busy=0, done=0, An=0, Dn_out=0, rd_data=0.
REQ-036 rst during any active phase SHALL abort the access: strobes high on the next edge, no done pulse, rd_data cleared, request discarded.
REQ-037 req asserted in the same cycle as rst SHALL be ignored.

Verification
REQ-038 Defaults, write adr=1 data=3'b101: NE low 8 cycles; NWE low last 6 of those with Dn_oe=1 and Dn_out=101; done pulses once; busy high 12 cycles.
REQ-039 Read adr=0, Dn_in=3'b110 during DATA: NOE low 6 cycles; Dn_oe=0 throughout; rd_data=110 when done=1.
REQ-040 req held high for two writes: exactly 5 cycles with NE=1 between the two NE-low windows; two done pulses.
REQ-041 rst=1 on the 3rd DATA cycle of a read: next edge NE=NOE=1, no done, rd_data=0, busy=0.
REQ-042 req toggled during an active access: bus waveform unchanged, no extra access started.
REQ-043 Loop back against the team's FSMC slave at ADDSET=1, DATAST=2, BUSTURN=3: write 3'b011 to adr 1, read adr 1 -> rd_data=011.
